alu_ex_stage_64bit: RTL and testbench
=====================================

// Module: alu_ex_stage_64bit
// PURPOSE
//  Registered EX-stage ALU for the 5-stage pipeline. Accepts operands and an opcode from
//  ID/EX over a valid/ready handshake, computes the 64-bit result and hands it to EX/MEM.
//  Two internal register stages, with backpressure and a flush for branch mispredicts.
//  Consumes the combinational ALU slices (bitwiseor_64bit and others) via alu_core_64bit.
// PARAMETERS
//  WIDTH     64  datapath width; only 64 is verified
//  RD_W      5   destination-register tag width
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      synchronous reset, active-low
//  flush      in   1      kill all in-flight ops; takes priority over everything except reset
//  in_valid   in   1      ID/EX offers an op
//  in_ready   out  1      stage accepts an op this cycle
//  in_op      in   4      opcode (see BEHAVIOUR)
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_rd      in   RD_W   destination tag, passed through unchanged
//  out_valid  out  1      result available to EX/MEM
//  out_ready  in   1      EX/MEM accepts the result
//  out_result out  WIDTH  ALU result
//  out_zero   out  1      out_result == 0
//  out_rd     out  RD_W   tag of the result
//  out_err    out  1      op was illegal (result forced to 0)
// BEHAVIOUR
//  - Reset (rst_n=0 at a clk edge): s1_valid=s2_valid=0; out_result=0, out_rd=0,
//    out_err=0, out_zero=1; in_ready=0 while rst_n=0.
//  - Opcodes: 0 AND, 1 OR, 2 XOR, 3 NOR, 4 ADD, 5 SUB, 6 SLL, 7 SRL, 8 SRA, 9 SLT (signed),
//    10 SLTU, 11 PASS_B. 12-15 are illegal: result=0, out_err=1.
//  - Arithmetic: ADD/SUB wrap modulo 2^64, with no overflow flag. Shifts use in_b[5:0] only.
//    SLT/SLTU return 64'd0 or 64'd1.
//  - Pipeline:
//      S1 registers op/a/b/rd.
//      S2 registers alu_core output (result, err, rd).
//      out_* are driven directly from S2.
//  - Stage advance rules:
//      adv2 = s1_valid & (~s2_valid | out_ready)
//      in_ready = rst_n & ~flush & (~s1_valid | adv2)
//    Transfer in = in_valid & in_ready; transfer out = out_valid & out_ready.
//  - Latency: 2 cycles from input accept to out_valid with out_ready=1.
//    Throughput is 1 op/cycle.
//  - Backpressure: with out_ready=0, S2 holds and S1 fills. in_ready then drops.
//    No op is lost or duplicated. out_* hold stable while out_valid & ~out_ready.
//  - Simultaneous accept and drain when full: S2 takes S1 and S1 takes the new op in the
//    same edge. Exactly one result leaves.
//  - Flush: at the edge, s1_valid=s2_valid=0. An input offered that cycle is dropped
//    (in_ready=0). The result at out_* is discarded even if out_ready=1 that cycle.
//    Data registers may keep stale values; only valids matter.
//  - Reset mid-operation has the same effect as flush, plus outputs return to their
//    reset values.
//  - out_zero is computed from the S2 result register, not recomputed combinationally
//    downstream.
// STRUCTURE
//  - alu_pkg (shared): opcode localparams (ALU_AND..ALU_PASSB), ALU_OP_W=4, illegal-op
//    range check function.
//  - Sub-module alu_core_64bit: purely combinational op mux, (op,a,b) -> (result,err).
//    Instantiates bitwiseor_64bit for OR/NOR. The top holds only handshake and registers.
// TESTING
//  1 Reset: hold rst_n=0 for 3 cycles, in_valid=1
//    -> out_valid=0, in_ready=0, out_result=0, out_zero=1.
//  2 OR: op=1, A=64'hAAAA_BBBB_CCCC_DDDD, B=64'h1111_2222_3333_4444, out_ready=1
//    -> 2 cycles later out_result=64'hBBBB_BBBB_FFFF_DDDD, out_zero=0.
//  3 Wrap and shift: ADD A=64'hFFFF_FFFF_FFFF_FFFF, B=1 -> result 0, out_zero=1.
//    SRA A=64'h8000_0000_0000_0000, B=64'h43 -> 64'hF000_0000_0000_0000.
//  4 Backpressure: stream 4 ORs, tags 1..4, with out_ready=0 for 5 cycles
//    -> in_ready drops after 2 accepts. Release: tags exit 1,2,3,4 in order,
//    no duplicates, out_* stable while stalled.
//  5 Flush: with S1 and S2 both full, assert flush for 1 cycle
//    -> next cycle out_valid=0. The op offered during flush never appears.
//    The next op appears after 2 cycles.
//  6 Illegal op: op=13, A=B=64'h1 -> out_result=0, out_err=1, out_zero=1,
//    and the next legal op has out_err=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and the illegal-opcode check.
package alu_pkg;

  localparam int ALU_OP_W = 4;

  localparam logic [ALU_OP_W-1:0] ALU_AND   = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_OR    = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_XOR   = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_NOR   = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_ADD   = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_SUB   = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SLL   = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SRL   = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_SRA   = 4'd8;
  localparam logic [ALU_OP_W-1:0] ALU_SLT   = 4'd9;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU  = 4'd10;
  localparam logic [ALU_OP_W-1:0] ALU_PASSB = 4'd11;

  // Everything above PASS_B (12..15) is unassigned and flagged as illegal.
  function automatic logic alu_illegal(input logic [ALU_OP_W-1:0] op);
    return op > ALU_PASSB;
  endfunction

endpackage

// File: rtl/alu_core_64bit.sv
// Purely combinational ALU op mux: (op, a, b) -> (result, err).
module alu_core_64bit
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic [ALU_OP_W-1:0] op_i,
  input  logic [WIDTH-1:0]    a_i,
  input  logic [WIDTH-1:0]    b_i,
  output logic [WIDTH-1:0]    result_o,
  output logic                err_o
);
  localparam int SH_W = $clog2(WIDTH);

  logic [WIDTH-1:0] or_y;
  logic [SH_W-1:0]  sh;

  assign sh = b_i[SH_W-1:0];

  bitwiseor_64bit #(.WIDTH(WIDTH)) u_or (.a_i(a_i), .b_i(b_i), .y_o(or_y));

  // Op select; illegal opcodes leave the result at zero and raise err.
  always_comb begin
    result_o = '0;
    err_o    = alu_illegal(op_i);
    case (op_i)
      ALU_AND:   result_o = a_i & b_i;
      ALU_OR:    result_o = or_y;
      ALU_XOR:   result_o = a_i ^ b_i;
      ALU_NOR:   result_o = ~or_y;
      ALU_ADD:   result_o = a_i + b_i;
      ALU_SUB:   result_o = a_i - b_i;
      ALU_SLL:   result_o = a_i << sh;
      ALU_SRL:   result_o = a_i >> sh;
      ALU_SRA:   result_o = $unsigned($signed(a_i) >>> sh);
      ALU_SLT:   result_o = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      ALU_SLTU:  result_o = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
      ALU_PASSB: result_o = b_i;
      default:   result_o = '0;
    endcase
  end
endmodule

// File: rtl/bitwiseor_64bit.sv
// Combinational bitwise OR slice, shared by the OR and NOR opcodes.
module bitwiseor_64bit #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o
);
  assign y_o = a_i | b_i;
endmodule

// File: rtl/alu_ex_stage_64bit.sv
// Two-stage registered EX ALU with valid/ready handshake, backpressure and flush.
// S1 holds the operands, S2 holds the ALU result; out_* come straight from S2.
module alu_ex_stage_64bit
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int RD_W  = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALU_OP_W-1:0] in_op,
  input  logic [WIDTH-1:0]    in_a,
  input  logic [WIDTH-1:0]    in_b,
  input  logic [RD_W-1:0]     in_rd,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_result,
  output logic                out_zero,
  output logic [RD_W-1:0]     out_rd,
  output logic                out_err
);
  logic                s1_valid_q, s2_valid_q;
  logic [ALU_OP_W-1:0] s1_op_q;
  logic [WIDTH-1:0]    s1_a_q, s1_b_q;
  logic [RD_W-1:0]     s1_rd_q, s2_rd_q;
  logic [WIDTH-1:0]    s2_result_q, core_result;
  logic                s2_err_q, s2_zero_q, core_err;
  logic                s1_valid_d, s2_valid_d;
  logic                adv2, in_fire;

  alu_core_64bit #(.WIDTH(WIDTH)) u_core (
    .op_i(s1_op_q), .a_i(s1_a_q), .b_i(s1_b_q),
    .result_o(core_result), .err_o(core_err)
  );

  // S2 can take S1 when it is empty or draining this cycle.
  assign adv2     = s1_valid_q & (~s2_valid_q | out_ready);
  assign in_ready = rst_n & ~flush & (~s1_valid_q | adv2);
  assign in_fire  = in_valid & in_ready;

  // Next-state valids: S1 refills on accept or holds if stuck; S2 refills or holds while stalled.
  always_comb begin
    s1_valid_d = in_fire | (s1_valid_q & ~adv2);
    s2_valid_d = adv2 | (s2_valid_q & ~out_ready);
  end

  // Stage registers; flush only clears valids, reset also clears the visible outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_rd_q     <= '0;
      s2_err_q    <= 1'b0;
      s2_zero_q   <= 1'b1;
    end else if (flush) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (in_fire) begin
        s1_op_q <= in_op;
        s1_a_q  <= in_a;
        s1_b_q  <= in_b;
        s1_rd_q <= in_rd;
      end
      if (adv2) begin
        s2_result_q <= core_result;
        s2_err_q    <= core_err;
        s2_zero_q   <= (core_result == '0);
        s2_rd_q     <= s1_rd_q;
      end
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = s2_result_q;
  assign out_zero   = s2_zero_q;
  assign out_rd     = s2_rd_q;
  assign out_err    = s2_err_q;
endmodule

// File: tb/tb_alu_ex_stage_64bit.sv
// Directed testbench for alu_ex_stage_64bit: vector table plus handshake sequences.
module tb_alu_ex_stage_64bit;
  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  in_op;
  logic [63:0] in_a, in_b, out_result;
  logic [4:0]  in_rd, out_rd;
  logic        out_zero, out_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_ex_stage_64bit dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_rd(out_rd), .out_err(out_err)
  );

  typedef struct {
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic        err;
    logic        zero;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    in_valid = 1'b0; in_op = 4'd0; in_a = '0; in_b = '0; in_rd = '0;
  endtask

  initial begin
    logic [63:0] hold_res;
    logic [4:0]  hold_rd;
    logic [4:0]  next_tag;
    logic [4:0]  seen[$];
    int          accepts;
    logic        saw7;

    vecs[0]  = '{4'd1,  64'hAAAA_BBBB_CCCC_DDDD, 64'h1111_2222_3333_4444, 64'hBBBB_BBBB_FFFF_DDDD, 1'b0, 1'b0};
    vecs[1]  = '{4'd4,  64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b0, 1'b1};
    vecs[2]  = '{4'd8,  64'h8000_0000_0000_0000, 64'h43, 64'hF000_0000_0000_0000, 1'b0, 1'b0};
    vecs[3]  = '{4'd0,  64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'hF000_F000_F000_F000, 1'b0, 1'b0};
    vecs[4]  = '{4'd2,  64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'h0FF0_0FF0_0FF0_0FF0, 1'b0, 1'b0};
    vecs[5]  = '{4'd3,  64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[6]  = '{4'd5,  64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
    vecs[7]  = '{4'd6,  64'h1, 64'h41, 64'h2, 1'b0, 1'b0};
    vecs[8]  = '{4'd7,  64'h8000_0000_0000_0000, 64'd63, 64'h1, 1'b0, 1'b0};
    vecs[9]  = '{4'd9,  64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h1, 1'b0, 1'b0};
    vecs[10] = '{4'd10, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b0, 1'b1};
    vecs[11] = '{4'd11, 64'h0, 64'h1234_5678, 64'h1234_5678, 1'b0, 1'b0};
    vecs[12] = '{4'd13, 64'h1, 64'h1, 64'h0, 1'b1, 1'b1};
    vecs[13] = '{4'd4,  64'h1, 64'h1, 64'h2, 1'b0, 1'b0};

    // Reset with an op offered
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    idle();
    in_valid = 1'b1; in_op = 4'd1; in_a = 64'h5; in_rd = 5'd9;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd0);
    chk("rst out_result", out_result, 64'd0);
    chk("rst out_zero", 64'(out_zero), 64'd1);
    chk("rst out_err", 64'(out_err), 64'd0);
    chk("rst out_rd", 64'(out_rd), 64'd0);
    rst_n = 1'b1;
    idle();
    @(negedge clk);

    // Table: one op at a time, checking the 2-cycle latency
    for (int i = 0; i < 14; i++) begin
      in_valid = 1'b1; in_op = vecs[i].op; in_a = vecs[i].a; in_b = vecs[i].b; in_rd = 5'(i + 1);
      #1;
      chk($sformatf("v%0d in_ready", i), 64'(in_ready), 64'd1);
      @(negedge clk);
      idle();
      chk($sformatf("v%0d early valid", i), 64'(out_valid), 64'd0);
      @(negedge clk);
      chk($sformatf("v%0d out_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("v%0d result", i), out_result, vecs[i].res);
      chk($sformatf("v%0d err", i), 64'(out_err), 64'(vecs[i].err));
      chk($sformatf("v%0d zero", i), 64'(out_zero), 64'(vecs[i].zero));
      chk($sformatf("v%0d rd", i), 64'(out_rd), 64'(i + 1));
    end
    @(negedge clk);

    // Backpressure: stream ORs tagged 1..4 with the output stalled for 5 cycles
    out_ready = 1'b0; next_tag = 5'd1; accepts = 0;
    hold_res = '0; hold_rd = '0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_op = 4'd1; in_a = 64'(next_tag); in_b = 64'(next_tag) << 8; in_rd = next_tag;
      #1;
      if (in_ready) begin accepts++; next_tag++; end
      if (c == 3) begin hold_res = out_result; hold_rd = out_rd; end
      if (c == 4) begin
        chk("bp stall valid", 64'(out_valid), 64'd1);
        chk("bp stall result stable", out_result, hold_res);
        chk("bp stall rd stable", 64'(out_rd), 64'(hold_rd));
        chk("bp stall rd", 64'(out_rd), 64'd1);
      end
      @(negedge clk);
    end
    chk("bp accepts before stall", 64'(accepts), 64'd2);
    out_ready = 1'b1;
    for (int c = 0; c < 20 && seen.size() < 4; c++) begin
      if (next_tag <= 5'd4) begin
        in_valid = 1'b1; in_a = 64'(next_tag); in_b = 64'(next_tag) << 8; in_rd = next_tag;
      end else idle();
      #1;
      if (in_valid && in_ready) next_tag++;
      if (out_valid) begin
        seen.push_back(out_rd);
        chk($sformatf("bp result tag%0d", out_rd), out_result, 64'(out_rd) | (64'(out_rd) << 8));
      end
      @(negedge clk);
    end
    idle();
    chk("bp drained count", 64'(seen.size()), 64'd4);
    for (int k = 0; k < seen.size(); k++)
      chk($sformatf("bp order %0d", k), 64'(seen[k]), 64'(k + 1));
    @(negedge clk);
    chk("bp empty after", 64'(out_valid), 64'd0);

    // Flush with both stages full
    out_ready = 1'b0;
    for (int t = 5; t <= 6; t++) begin
      in_valid = 1'b1; in_op = 4'd11; in_b = 64'(t); in_rd = 5'(t);
      @(negedge clk);
    end
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_b = 64'd7; in_rd = 5'd7;
    #1;
    chk("flush in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    flush = 1'b0; idle();
    chk("flush out_valid", 64'(out_valid), 64'd0);
    saw7 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (out_valid) saw7 = 1'b1;
    end
    chk("flush dropped op", 64'(saw7), 64'd0);
    in_valid = 1'b1; in_op = 4'd11; in_b = 64'd8; in_rd = 5'd8;
    @(negedge clk);
    idle();
    chk("post flush early", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk("post flush valid", 64'(out_valid), 64'd1);
    chk("post flush rd", 64'(out_rd), 64'd8);
    chk("post flush result", out_result, 64'd8);

    // Reset mid-operation behaves like flush plus output reset
    in_valid = 1'b1; in_op = 4'd11; in_b = 64'd9; in_rd = 5'd9; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; idle();
    chk("midrst out_valid", 64'(out_valid), 64'd0);
    chk("midrst out_result", out_result, 64'd0);
    chk("midrst out_zero", 64'(out_zero), 64'd1);
    chk("midrst out_rd", 64'(out_rd), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
